// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point datapath.
//   - operation encodings (FP_OP_ADD / FP_OP_SUB / FP_OP_MUL; 2'b11 is reserved)
//   - operand class enum produced by fp_unpack_classify
//   - fp_qnan(): canonical quiet NaN {0, all-ones exponent, 1 followed by zeros}
//     for any exponent/mantissa width up to 127 bits in total
package fp_pkg;

    localparam logic [1:0] FP_OP_ADD = 2'b00;
    localparam logic [1:0] FP_OP_SUB = 2'b01;
    localparam logic [1:0] FP_OP_MUL = 2'b10;

    typedef enum logic [2:0] {
        FP_CLS_ZERO    = 3'd0,
        FP_CLS_SUBNORM = 3'd1,
        FP_CLS_NORMAL  = 3'd2,
        FP_CLS_INF     = 3'd3,
        FP_CLS_QNAN    = 3'd4,
        FP_CLS_SNAN    = 3'd5
    } fp_class_e;

    function automatic logic [127:0] fp_qnan(input int exp_w, input int man_w);
        logic [127:0] exp_ones;
        exp_ones = (128'(1) << exp_w) - 128'(1);
        return (exp_ones << man_w) | (128'(1) << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_unpack_classify.sv
// Combinational unpack and classification of one raw IEEE-754 operand.
// Configuration macro: FP_SUBNORM_EN
//   defined   -> subnormals are classed FP_CLS_SUBNORM (hidden bit 0, exp 1)
//   undefined -> subnormals are flushed: classed FP_CLS_ZERO, mantissa 0
// Ports:
//   word      in   raw operand {sign, exponent, stored mantissa}
//   sign      out  sign bit
//   cls       out  operand class
//   exp_eff   out  effective exponent (1 when the stored exponent is 0)
//   man_full  out  mantissa with hidden bit prepended
module fp_unpack_classify
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic [W-1:0]     word,
    output logic             sign,
    output fp_class_e        cls,
    output logic [EXP_W-1:0] exp_eff,
    output logic [MAN_W:0]   man_full
);

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;
    logic             exp_max;
    logic             exp_zero;
    logic             man_zero;

    assign sign     = word[W-1];
    assign exp_f    = word[W-2:MAN_W];
    assign man_f    = word[MAN_W-1:0];
    assign exp_max  = &exp_f;
    assign exp_zero = ~|exp_f;
    assign man_zero = ~|man_f;

    always_comb begin
        cls = FP_CLS_NORMAL;
        if (exp_max) begin
            if (man_zero)
                cls = FP_CLS_INF;
            else if (man_f[MAN_W-1])
                cls = FP_CLS_QNAN;
            else
                cls = FP_CLS_SNAN;
        end else if (exp_zero) begin
            if (man_zero)
                cls = FP_CLS_ZERO;
            else
`ifdef FP_SUBNORM_EN
                cls = FP_CLS_SUBNORM;
`else
                cls = FP_CLS_ZERO;
`endif
        end
    end

    assign exp_eff = exp_zero ? {{(EXP_W-1){1'b0}}, 1'b1} : exp_f;

`ifdef FP_SUBNORM_EN
    assign man_full = {~exp_zero, man_f};
`else
    // A flushed subnormal carries no mantissa bits forward.
    assign man_full = exp_zero ? '0 : {1'b1, man_f};
`endif

endmodule

// File: rtl/fp_special_case_stage.sv
// Special-case stage: resolves NaN / infinity / zero operands into a final
// bypass word, otherwise forwards unpacked operands to the alignment stage.
// One output register plus one skid entry; in_ready depends only on state.
// Configuration macro: FP_SUBNORM_EN (see fp_unpack_classify).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        upstream handshake
//   in_op, in_a, in_b        operation code and raw operands
//   out_valid/out_ready      downstream handshake
//   out_bypass, out_result   final word valid when out_bypass=1 (else 0)
//   out_op                   registered operation code
//   out_sign_a, out_sign_b   sign A, effective sign B
//   out_exp_a/b, out_man_a/b effective exponents, mantissas with hidden bit
//   out_exp_diff             |exp_a - exp_b|
//   out_a_bigger             |A| >= |B|
//   flag_invalid, flag_clear sticky invalid-operation flag and its clear
module fp_special_case_stage
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bypass,
    output logic [W-1:0]     out_result,
    output logic [1:0]       out_op,
    output logic             out_sign_a,
    output logic             out_sign_b,
    output logic [EXP_W-1:0] out_exp_a,
    output logic [EXP_W-1:0] out_exp_b,
    output logic [MAN_W:0]   out_man_a,
    output logic [MAN_W:0]   out_man_b,
    output logic [EXP_W-1:0] out_exp_diff,
    output logic             out_a_bigger,
    output logic             flag_invalid,
    input  logic             flag_clear
);

    localparam logic [W-1:0] QNAN = W'(fp_qnan(EXP_W, MAN_W));
    localparam int P_W = 1 + W + 2 + 2 + 3 * EXP_W + 2 * (MAN_W + 1) + 1;

    logic             sign_a, sign_b;
    fp_class_e        cls_a, cls_b;
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W:0]   man_a, man_b;

    fp_unpack_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
        .word(in_a), .sign(sign_a), .cls(cls_a), .exp_eff(exp_a), .man_full(man_a)
    );
    fp_unpack_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
        .word(in_b), .sign(sign_b), .cls(cls_b), .exp_eff(exp_b), .man_full(man_b)
    );

    // Stage p0: bypass resolution on the incoming operands
    logic             sign_b_eff_p0, is_mul_p0;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic             bypass_p0, invalid_p0, a_bigger_p0;
    logic [W-1:0]     result_p0;
    logic [EXP_W-1:0] exp_diff_p0;
    logic [P_W-1:0]   payload_p0;

    assign sign_b_eff_p0 = sign_b ^ (in_op == FP_OP_SUB);
    assign is_mul_p0     = (in_op == FP_OP_MUL);
    assign a_nan  = (cls_a == FP_CLS_QNAN) || (cls_a == FP_CLS_SNAN);
    assign b_nan  = (cls_b == FP_CLS_QNAN) || (cls_b == FP_CLS_SNAN);
    assign a_inf  = (cls_a == FP_CLS_INF);
    assign b_inf  = (cls_b == FP_CLS_INF);
    assign a_zero = (cls_a == FP_CLS_ZERO);
    assign b_zero = (cls_b == FP_CLS_ZERO);

    always_comb begin
        bypass_p0  = 1'b1;
        invalid_p0 = 1'b0;
        result_p0  = '0;
        if (a_nan || b_nan) begin
            // Propagate the first NaN, quieted.
            result_p0  = a_nan ? {in_a[W-1], {EXP_W{1'b1}}, 1'b1, in_a[MAN_W-2:0]}
                               : {in_b[W-1], {EXP_W{1'b1}}, 1'b1, in_b[MAN_W-2:0]};
            invalid_p0 = (cls_a == FP_CLS_SNAN) || (cls_b == FP_CLS_SNAN);
        end else if (a_inf || b_inf) begin
            if (is_mul_p0) begin
                if (a_zero || b_zero) begin
                    result_p0  = QNAN;
                    invalid_p0 = 1'b1;
                end else begin
                    result_p0 = {sign_a ^ sign_b, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                end
            end else if (a_inf && b_inf && (sign_a != sign_b_eff_p0)) begin
                result_p0  = QNAN;
                invalid_p0 = 1'b1;
            end else begin
                result_p0 = {a_inf ? sign_a : sign_b_eff_p0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
        end else if (a_zero || b_zero) begin
            if (is_mul_p0)
                result_p0 = {sign_a ^ sign_b, {(W-1){1'b0}}};
            else if (a_zero && b_zero)
                result_p0 = {sign_a & sign_b_eff_p0, {(W-1){1'b0}}};
            else if (a_zero)
                result_p0 = {sign_b_eff_p0, in_b[W-2:0]};
            else
                result_p0 = in_a;
        end else begin
            bypass_p0 = 1'b0;
        end
    end

    assign exp_diff_p0 = (exp_a >= exp_b) ? (exp_a - exp_b) : (exp_b - exp_a);
    assign a_bigger_p0 = {exp_a, man_a} >= {exp_b, man_b};
    assign payload_p0  = {bypass_p0, result_p0, in_op, sign_a, sign_b_eff_p0,
                          exp_a, exp_b, man_a, man_b, exp_diff_p0, a_bigger_p0};

    // Stage p1: output register and skid entry
    logic [P_W-1:0] main_p1, skid_p1;
    logic           vld_p1, skid_vld_p1;
    logic           accept;

    assign in_ready = ~skid_vld_p1;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            main_p1     <= '0;
            skid_p1     <= '0;
        end else if (!vld_p1 || out_ready) begin
            // Main register drains or is empty: refill from skid first to keep order.
            if (skid_vld_p1) begin
                main_p1     <= skid_p1;
                vld_p1      <= 1'b1;
                skid_vld_p1 <= 1'b0;
            end else if (accept) begin
                main_p1 <= payload_p0;
                vld_p1  <= 1'b1;
            end else begin
                vld_p1 <= 1'b0;
            end
        end else if (accept) begin
            skid_p1     <= payload_p0;
            skid_vld_p1 <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flag_invalid <= 1'b0;
        else if (accept && invalid_p0)
            flag_invalid <= 1'b1;
        else if (flag_clear)
            flag_invalid <= 1'b0;
    end

    assign out_valid = vld_p1;
    assign {out_bypass, out_result, out_op, out_sign_a, out_sign_b,
            out_exp_a, out_exp_b, out_man_a, out_man_b, out_exp_diff, out_a_bigger} = main_p1;

endmodule

// File: tb/tb_fp_special_case_stage.sv
module tb_fp_special_case_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'b00;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_bypass;
    logic [31:0] out_result;
    logic [1:0]  out_op;
    logic        out_sign_a, out_sign_b;
    logic [7:0]  out_exp_a, out_exp_b, out_exp_diff;
    logic [23:0] out_man_a, out_man_b;
    logic        out_a_bigger;
    logic        flag_invalid;
    logic        flag_clear = 1'b0;

    fp_special_case_stage #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bypass(out_bypass), .out_result(out_result), .out_op(out_op),
        .out_sign_a(out_sign_a), .out_sign_b(out_sign_b),
        .out_exp_a(out_exp_a), .out_exp_b(out_exp_b),
        .out_man_a(out_man_a), .out_man_b(out_man_b),
        .out_exp_diff(out_exp_diff), .out_a_bigger(out_a_bigger),
        .flag_invalid(flag_invalid), .flag_clear(flag_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        bypass;
        logic [31:0] result;
        logic [1:0]  op;
        logic        chk_path;
        logic [7:0]  exp_a, exp_b, exp_diff;
        logic        a_bigger;
        logic [23:0] man_a;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_acc = 0;
    int   n_out = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic exp_t xb(input logic [1:0] op, input logic [31:0] r);
        exp_t e;
        e.bypass = 1'b1; e.result = r; e.op = op; e.chk_path = 1'b0;
        e.exp_a = '0; e.exp_b = '0; e.exp_diff = '0; e.a_bigger = 1'b0; e.man_a = '0;
        return e;
    endfunction

    function automatic exp_t xn(input logic [1:0] op, input logic [7:0] ea, input logic [7:0] eb,
                                input logic [7:0] ed, input logic ab, input logic [23:0] ma);
        exp_t e;
        e.bypass = 1'b0; e.result = '0; e.op = op; e.chk_path = 1'b1;
        e.exp_a = ea; e.exp_b = eb; e.exp_diff = ed; e.a_bigger = ab; e.man_a = ma;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input exp_t e);
        int n;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
        end else begin
            sbq.push_back(e);
            n_acc++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: a transfer happens on the next rising edge when both are high.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL out_unexpected: result %h, expected no output", out_result);
                end else begin
                    e = sbq.pop_front();
                    chk($sformatf("out%0d_bypass", n_out), 32'(out_bypass), 32'(e.bypass));
                    chk($sformatf("out%0d_result", n_out), out_result, e.result);
                    chk($sformatf("out%0d_op", n_out), 32'(out_op), 32'(e.op));
                    if (e.chk_path) begin
                        chk($sformatf("out%0d_exp_a", n_out), 32'(out_exp_a), 32'(e.exp_a));
                        chk($sformatf("out%0d_exp_b", n_out), 32'(out_exp_b), 32'(e.exp_b));
                        chk($sformatf("out%0d_exp_diff", n_out), 32'(out_exp_diff), 32'(e.exp_diff));
                        chk($sformatf("out%0d_a_bigger", n_out), 32'(out_a_bigger), 32'(e.a_bigger));
                        chk($sformatf("out%0d_man_a", n_out), 32'(out_man_a), 32'(e.man_a));
                    end
                    n_out++;
                end
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_result", out_result, 32'h0);
        chk("rst_exp_a", 32'(out_exp_a), 32'd0);
        chk("rst_flag", 32'(flag_invalid), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // inf - inf -> canonical qNaN, invalid
        send(2'b01, 32'h7F800000, 32'h7F800000, xb(2'b01, 32'h7FC00000));
        chk("flag_inf_sub", 32'(flag_invalid), 32'd1);
        flag_clear = 1'b1;
        @(posedge clk);
        #1;
        flag_clear = 1'b0;
        chk("flag_clear1", 32'(flag_invalid), 32'd0);

        // inf * 0 -> canonical qNaN, invalid
        send(2'b10, 32'h7F800000, 32'h00000000, xb(2'b10, 32'h7FC00000));
        chk("flag_inf_mul0", 32'(flag_invalid), 32'd1);
        flag_clear = 1'b1;
        @(posedge clk);
        #1;
        flag_clear = 1'b0;
        chk("flag_clear2", 32'(flag_invalid), 32'd0);

        // sNaN with clear held: set wins over same-cycle clear
        flag_clear = 1'b1;
        send(2'b00, 32'h7F800001, 32'h3F800000, xb(2'b00, 32'h7FC00001));
        chk("flag_snan_set_wins", 32'(flag_invalid), 32'd1);
        @(posedge clk);
        #1;
        flag_clear = 1'b0;
        chk("flag_clear3", 32'(flag_invalid), 32'd0);

        // Signed zeros
        send(2'b01, 32'h80000000, 32'h00000000, xb(2'b01, 32'h80000000));
        send(2'b00, 32'h80000000, 32'h00000000, xb(2'b00, 32'h00000000));
        // Quiet NaN in B propagates unchanged, no invalid
        send(2'b10, 32'h3F800000, 32'hFFC12345, xb(2'b10, 32'hFFC12345));
        // Infinity sign handling
        send(2'b00, 32'hFF800000, 32'h3F800000, xb(2'b00, 32'hFF800000));
        send(2'b10, 32'h7F800000, 32'hBF800000, xb(2'b10, 32'hFF800000));
        send(2'b01, 32'h3F800000, 32'h7F800000, xb(2'b01, 32'hFF800000));
        send(2'b10, 32'h80000000, 32'h40000000, xb(2'b10, 32'h80000000));
        chk("flag_quiet_ops", 32'(flag_invalid), 32'd0);
        // Reserved op behaves as add: inf + (-inf) -> qNaN
        send(2'b11, 32'h7F800000, 32'hFF800000, xb(2'b11, 32'h7FC00000));
        chk("flag_reserved_op", 32'(flag_invalid), 32'd1);
        flag_clear = 1'b1;
        @(posedge clk);
        #1;
        flag_clear = 1'b0;

        // Normal path
        send(2'b00, 32'h3F800000, 32'h40000000, xn(2'b00, 8'd127, 8'd128, 8'd1, 1'b0, 24'h800000));
        send(2'b01, 32'h40400000, 32'h3F800000, xn(2'b01, 8'd128, 8'd127, 8'd1, 1'b1, 24'hC00000));
        send(2'b00, 32'h3F800000, 32'hBF800000, xn(2'b00, 8'd127, 8'd127, 8'd0, 1'b1, 24'h800000));

        // Subnormal operand
`ifdef FP_SUBNORM_EN
        send(2'b00, 32'h00000001, 32'h3F800000, xn(2'b00, 8'd1, 8'd127, 8'd126, 1'b0, 24'h000001));
`else
        send(2'b00, 32'h00000001, 32'h3F800000, xb(2'b00, 32'h3F800000));
`endif

        // Stall: three inputs offered, two accepted, then ordered drain
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        n = n_acc;
        fork
            begin
                send(2'b00, 32'h00000000, 32'h3F800000, xb(2'b00, 32'h3F800000));
                send(2'b00, 32'h40400000, 32'h00000000, xb(2'b00, 32'h40400000));
                send(2'b01, 32'h00000000, 32'h40A00000, xb(2'b01, 32'hC0A00000));
            end
            begin
                repeat (6) @(negedge clk);
                chk("stall_accepted", 32'(n_acc - n), 32'd2);
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                chk("stall_out_valid", 32'(out_valid), 32'd1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join

        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_pending", 32'(sbq.size()), 32'd0);
        @(negedge clk);
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("total_outputs", 32'(n_out), 32'(n_acc));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fp_special_case_stage.md
# fp_special_case_stage

Parametrised, flow-controlled special-case stage for the floating-point datapath. It sits between operand unpack and the alignment stage. It accepts raw IEEE-754 operands of configurable exponent and mantissa width plus an operation code (add, sub, mul). It resolves NaN, infinity, zero and (optionally) subnormal cases into a bypass result, or forwards unpacked operands for the arithmetic path. A valid/ready handshake with a 2-entry skid buffer and sticky exception flags are included.

## Interface
- EXP_W, 8, exponent width
- MAN_W, 23, stored mantissa width (no hidden bit); W = 1+EXP_W+MAN_W
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid / in_ready  in / out  1  upstream handshake; transfer when both high
- in_op  in  2  00 add, 01 sub, 10 mul, 11 reserved (treated as add)
- in_a, in_b  in  W  raw operands
- out_valid / out_ready  out / in  1  downstream handshake
- out_bypass  out  1  result is final; arithmetic path must not compute
- out_result  out  W  final word when out_bypass=1, else 0
- out_op  out  2  registered in_op
- out_sign_a, out_sign_b  out  1  sign A; effective sign B (sign_b ^ (op==sub))
- out_exp_a, out_exp_b  out  EXP_W  effective exponents
- out_man_a, out_man_b  out  MAN_W+1  mantissas with hidden bit
- out_exp_diff  out  EXP_W  |exp_a − exp_b| of effective exponents
- out_a_bigger  out  1  |A| ≥ |B| (tie → 1)
- flag_invalid  out  1  sticky invalid-operation flag
- flag_clear  in  1  synchronous clear of sticky flags

## Operation
- Classify each operand: NaN (exp all-ones, man≠0), sNaN (NaN with man MSB=0), inf, zero, subnormal (exp=0, man≠0), normal.
- Priority: NaN > inf > zero > normal path. Bypass sets out_bypass=1.
- NaN: result = first NaN (A before B) with its sign, exp all-ones, payload with man MSB forced to 1. Any sNaN input sets invalid.
- Add/sub infinities: inf − inf (opposite effective signs) → canonical qNaN {0, all-ones, 1 followed by zeros}, invalid. Otherwise → inf carrying the inf operand's sign (A's if both).
- Add/sub zeros: both zero → sign_a & sign_b_eff (round-to-nearest rule), exp=0, man=0. One zero → the other operand, with effective sign for B.
- Mul: inf×0 → canonical qNaN, invalid. inf×x → inf, zero×x → zero; sign = sign_a ^ sign_b.
- Normal path: hidden bit = (exp≠0); effective exponent of a subnormal = 1. out_a_bigger compares {exp, man}.
- flag_invalid sets on the input handshake of an invalid-producing transaction. flag_clear clears it. Set wins over a same-cycle clear.

## Timing
- Latency 1 cycle from the input handshake to out_valid, when unstalled. Throughput 1 per cycle.
- Skid buffer: main output register plus one skid entry. in_ready = !skid_valid (registered, no combinational path from out_ready).
- Stalled output with an accepted input → input captured into skid, in_ready drops next cycle.
- On out handshake, skid (if occupied) moves to main; otherwise main loads new input or clears out_valid.
- Order is strictly preserved. No transaction is dropped or duplicated.
- Reset: out_valid=0, skid empty, in_ready=1, all data outputs 0, flag_invalid=0. Reset mid-stream discards both entries.

## Configuration
- FP_SUBNORM_EN defined: subnormals follow the normal path (hidden bit 0, effective exp 1).
- FP_SUBNORM_EN undefined: subnormal inputs are flushed to zero of the same sign and then follow the zero rules. No flag is raised.

## Structure
- Shared package fp_pkg holds:
  - op encodings (FP_OP_ADD/SUB/MUL)
  - operand class enum
  - canonical qNaN constant/function parametrised by EXP_W/MAN_W
- Sub-module fp_unpack_classify (combinational, instanced per operand) produces class bits, effective exp and mantissa with hidden bit.
- The top module holds bypass resolution, skid buffer and flags.

## Test plan
- Defaults used throughout (EXP_W=8, MAN_W=23).
- A=0x7F800000, B=0x7F800000, sub → bypass, 0x7FC00000, flag_invalid=1. Same operands with mul and B=0x00000000 → 0x7FC00000.
- A=0x7F800001 (sNaN), B=0x3F800000, add → 0x7FC00001, flag_invalid=1. flag_clear then → 0.
- A=0x80000000, B=0x00000000, sub → 0x80000000. Same operands with add → 0x00000000.
- A=0x3F800000, B=0x40000000, add → bypass=0, exp_a=127, exp_b=128, exp_diff=1, a_bigger=0, man_a=0x800000.
- out_ready=0 while 3 back-to-back inputs are offered → exactly 2 accepted, in_ready low. Release → outputs in order, third then accepted.
- A=0x00000001, B=0x3F800000, add → with FP_SUBNORM_EN: bypass=0, exp_a=1, man_a=0x000001. Without it: bypass=1, result 0x3F800000.
